mult_div_sequencer: RTL and testbench



---
 rtl/mult_div_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
// Iterative multiply/divide unit with the architectural HI/LO registers.
// Sits beside the EX-stage ALU and executes MULT/MULTU/DIV/DIVU (one bit
// per clock) plus the HI/LO moves MFHI/MFLO/MTHI/MTLO. While an operation is
// in flight it stalls the pipeline so the instruction is held upstream.
//
// Ports:
//   i_clk     clock, all state updates on the rising edge
//   i_reset   asynchronous active-high reset
//   i_Start   EX stage holds a valid mult/div-class instruction this cycle
//   i_Funct   R-type funct field selecting the operation
//   i_RS      rs operand (multiplicand / dividend / MTHI-MTLO source)
//   i_RT      rt operand (multiplier / divisor)
//   o_Result  HI for MFHI, LO for MFLO, otherwise 0 (combinational)
//   o_Busy    a multiply/divide is in flight (MUL, DIV or FIX state)
//   o_Stall   freeze PC/IF/ID/EX while the unit cannot take i_Start
//   o_Done    one-cycle pulse in the cycle after HI/LO are written
module mult_div_sequencer #(
  parameter int NBITS      = 32,
  parameter int NBITSFUNCT = 6,
  parameter int NBITSCNT   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_Start,
  input  logic [NBITSFUNCT-1:0] i_Funct,
  input  logic [NBITS-1:0]      i_RS,
  input  logic [NBITS-1:0]      i_RT,
  output logic [NBITS-1:0]      o_Result,
  output logic                  o_Busy,
  output logic                  o_Stall,
  output logic                  o_Done
);

  localparam logic [NBITSFUNCT-1:0] F_MFHI  = NBITSFUNCT'(6'b010000);
  localparam logic [NBITSFUNCT-1:0] F_MTHI  = NBITSFUNCT'(6'b010001);
  localparam logic [NBITSFUNCT-1:0] F_MFLO  = NBITSFUNCT'(6'b010010);
  localparam logic [NBITSFUNCT-1:0] F_MTLO  = NBITSFUNCT'(6'b010011);
  localparam logic [NBITSFUNCT-1:0] F_MULT  = NBITSFUNCT'(6'b011000);
  localparam logic [NBITSFUNCT-1:0] F_MULTU = NBITSFUNCT'(6'b011001);
  localparam logic [NBITSFUNCT-1:0] F_DIV   = NBITSFUNCT'(6'b011010);
  localparam logic [NBITSFUNCT-1:0] F_DIVU  = NBITSFUNCT'(6'b011011);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_reg;
  logic [NBITS-1:0]      hi_reg;
  logic [NBITS-1:0]      lo_reg;
  // Multiplicand (MUL) or divisor (DIV) magnitude.
  logic [NBITS-1:0]      opa_reg;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*NBITS-1:0]    acc_reg;
  logic [NBITSCNT-1:0]   cnt_reg;
  logic                  is_div_reg;
  logic                  neg_q_reg;     // negate product (MUL) or quotient (DIV)
  logic                  neg_r_reg;     // negate remainder (DIV only)
  logic                  div_zero_reg;
  logic                  busy_reg;
  logic                  done_reg;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  logic is_mul_op, is_div_op, is_signed_op, accept_md;
  logic rs_neg, rt_neg;
  logic [NBITS-1:0] rs_abs, rt_abs;

  always_comb begin
    is_mul_op    = (i_Funct == F_MULT) || (i_Funct == F_MULTU);
    is_div_op    = (i_Funct == F_DIV)  || (i_Funct == F_DIVU);
    is_signed_op = (i_Funct == F_MULT) || (i_Funct == F_DIV);
    accept_md    = i_Start && (state_reg == S_IDLE) && (is_mul_op || is_div_op);
    rs_neg       = is_signed_op && i_RS[NBITS-1];
    rt_neg       = is_signed_op && i_RT[NBITS-1];
    // The magnitude of the most negative value is 2^(NBITS-1), which still
    // fits as an unsigned NBITS-bit number, so no extra bit is kept.
    rs_abs       = rs_neg ? (~i_RS + NBITS'(1)) : i_RS;
    rt_abs       = rt_neg ? (~i_RT + NBITS'(1)) : i_RT;
  end

  // ---------------------------------------------------------------------
  // One iteration of shift-add multiply
  // ---------------------------------------------------------------------
  logic [NBITS:0]     mul_sum;
  logic [2*NBITS-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*NBITS-1:NBITS]}
             + {1'b0, (acc_reg[0] ? opa_reg : {NBITS{1'b0}})};
    // Carry drops into the top of the accumulator as everything shifts right.
    mul_next = {mul_sum, acc_reg[NBITS-1:1]};
  end

  // ---------------------------------------------------------------------
  // One iteration of restoring division
  // ---------------------------------------------------------------------
  logic [NBITS:0]     div_shifted;
  logic               div_ge;
  logic [NBITS-1:0]   div_sub;
  logic [2*NBITS-1:0] div_next;

  always_comb begin
    div_shifted = {acc_reg[2*NBITS-1:NBITS], acc_reg[NBITS-1]};
    div_ge      = (div_shifted >= {1'b0, opa_reg});
    // When the subtraction succeeds the true difference is below the divisor,
    // so computing it modulo 2^NBITS loses nothing.
    div_sub     = div_shifted[NBITS-1:0] - opa_reg;
    div_next    = {(div_ge ? div_sub : div_shifted[NBITS-1:0]),
                   acc_reg[NBITS-2:0], div_ge};
  end

  // ---------------------------------------------------------------------
  // Sign fix-up of the finished magnitude result
  // ---------------------------------------------------------------------
  logic [2*NBITS-1:0] prod_fix;
  logic [NBITS-1:0]   quot_fix;
  logic [NBITS-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q_reg ? (-acc_reg) : acc_reg;
    // Divide by zero yields an all-ones quotient regardless of signs; the
    // remainder path already reproduces the original dividend.
    if (div_zero_reg)
      quot_fix = {NBITS{1'b1}};
    else
      quot_fix = neg_q_reg ? (-acc_reg[NBITS-1:0]) : acc_reg[NBITS-1:0];
    rem_fix  = neg_r_reg ? (-acc_reg[2*NBITS-1:NBITS]) : acc_reg[2*NBITS-1:NBITS];
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= S_IDLE;
      hi_reg       <= '0;
      lo_reg       <= '0;
      opa_reg      <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_Start) begin
            if (is_mul_op) begin
              opa_reg      <= rs_abs;
              acc_reg      <= {{NBITS{1'b0}}, rt_abs};
              neg_q_reg    <= rs_neg ^ rt_neg;
              neg_r_reg    <= 1'b0;
              div_zero_reg <= 1'b0;
              is_div_reg   <= 1'b0;
              cnt_reg      <= NBITSCNT'(NBITS);
              busy_reg     <= 1'b1;
              state_reg    <= S_MUL;
            end else if (is_div_op) begin
              opa_reg      <= rt_abs;
              acc_reg      <= {{NBITS{1'b0}}, rs_abs};
              neg_q_reg    <= rs_neg ^ rt_neg;
              neg_r_reg    <= rs_neg;
              div_zero_reg <= (i_RT == '0);
              is_div_reg   <= 1'b1;
              cnt_reg      <= NBITSCNT'(NBITS);
              busy_reg     <= 1'b1;
              state_reg    <= S_DIV;
            end else if (i_Funct == F_MTHI) begin
              hi_reg <= i_RS;
            end else if (i_Funct == F_MTLO) begin
              lo_reg <= i_RS;
            end
          end
        end

        S_MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg - NBITSCNT'(1);
          if (cnt_reg == NBITSCNT'(1))
            state_reg <= S_FIX;
        end

        S_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg - NBITSCNT'(1);
          if (cnt_reg == NBITSCNT'(1))
            state_reg <= S_FIX;
        end

        S_FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[2*NBITS-1:NBITS];
            lo_reg <= prod_fix[NBITS-1:0];
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end

        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_Busy  = busy_reg;
  assign o_Done  = done_reg;
  // The instruction is held upstream for the whole operation including the
  // DONE cycle, so it is not re-accepted until the unit is back in IDLE.
  assign o_Stall = i_Start && (busy_reg || (state_reg == S_DONE) || accept_md);

  always_comb begin
    if (i_Funct == F_MFHI)
      o_Result = hi_reg;
    else if (i_Funct == F_MFLO)
      o_Result = lo_reg;
    else
      o_Result = '0;
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed vector table, a few
// hand-written multi-cycle sequences, and randomized operations checked
// against a plain-arithmetic reference model.
module tb_mult_div_sequencer;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_BAD   = 6'b100000;

  logic        i_clk;
  logic        i_reset;
  logic        i_Start;
  logic [5:0]  i_Funct;
  logic [31:0] i_RS;
  logic [31:0] i_RT;
  logic [31:0] o_Result;
  logic        o_Busy;
  logic        o_Stall;
  logic        o_Done;

  int tests_run;
  int tests_failed;

  mult_div_sequencer dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_Start  (i_Start),
    .i_Funct  (i_Funct),
    .i_RS     (i_RS),
    .i_RT     (i_RT),
    .o_Result (o_Result),
    .o_Busy   (o_Busy),
    .o_Stall  (o_Stall),
    .o_Done   (o_Done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic string fname(input logic [5:0] f);
    case (f)
      F_MULT:  return "MULT";
      F_MULTU: return "MULTU";
      F_DIV:   return "DIV";
      F_DIVU:  return "DIVU";
      default: return "OTHER";
    endcase
  endfunction

  // Reference: the architectural result computed with 64-bit arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] rs,
                                input logic [31:0] rt,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    hi = '0;
    lo = '0;
    case (f)
      F_MULT: begin
        sq = sa * sb;
        hi = sq[63:32];
        lo = sq[31:0];
      end
      F_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        hi = up[63:32];
        lo = up[31:0];
      end
      F_DIV: begin
        if (rt == 32'd0) begin
          hi = rs;
          lo = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          hi = sr[31:0];
          lo = sq[31:0];
        end
      end
      F_DIVU: begin
        if (rt == 32'd0) begin
          hi = rs;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = rs % rt;
          lo = rs / rt;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue a MULT/DIV-class op from IDLE (called at posedge+1), hold it while
  // stalled, then read HI/LO back with MFHI/MFLO.
  task automatic run_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          stall_n;
    int          done_at;
    int          cyc;
    logic        stall_in_done;
    logic [31:0] got_hi, got_lo;
    i_Start = 1'b1;
    i_Funct = f;
    i_RS    = rs;
    i_RT    = rt;
    stall_n = 0;
    done_at = -1;
    cyc     = 0;
    stall_in_done = 1'b0;
    while (done_at < 0 && cyc < 100) begin
      #4;
      if (o_Done) begin
        done_at       = cyc;
        stall_in_done = o_Stall;
      end else if (o_Stall) begin
        stall_n++;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_Start = 1'b0;
    chk("done_cycle", 32'(done_at), 32'd34);
    chk("stall_cycles_before_done", 32'(stall_n), 32'd34);
    chk("stall_in_done", 32'(stall_in_done), 32'd1);
    #2;
    chk("done_single_pulse", 32'(o_Done), 32'd0);
    chk("busy_after_done", 32'(o_Busy), 32'd0);
    i_Start = 1'b1;
    i_Funct = F_MFHI;
    #1;
    got_hi = o_Result;
    chk("mfhi_result", got_hi, exp_hi);
    chk("mfhi_no_stall", 32'(o_Stall), 32'd0);
    i_Funct = F_MFLO;
    #1;
    got_lo = o_Result;
    chk("mflo_result", got_lo, exp_lo);
    @(posedge i_clk);
    #1;
    i_Start = 1'b0;
    $display("[TB] %s rs=%h rt=%h -> hi=%h lo=%h (exp hi=%h lo=%h) stall=%0d done_at=%0d",
             fname(f), rs, rt, got_hi, got_lo, exp_hi, exp_lo, stall_n, done_at);
  endtask

  initial begin
    logic [5:0]  rf;
    logic [31:0] rrs, rrt, ehi, elo;
    int          n;
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    // Reset state
    i_reset = 1'b1;
    i_Start = 1'b0;
    i_Funct = 6'd0;
    i_RS    = 32'd0;
    i_RT    = 32'd0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_busy", 32'(o_Busy), 32'd0);
    chk("reset_done", 32'(o_Done), 32'd0);
    chk("reset_stall", 32'(o_Stall), 32'd0);
    i_Funct = F_MFHI;
    #1;
    chk("reset_hi", o_Result, 32'd0);
    i_Funct = F_MFLO;
    #1;
    chk("reset_lo", o_Result, 32'd0);
    i_Funct = 6'd0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 10; i++)
      run_md(vecs[i].f, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

    // MTHI in IDLE: single cycle, no stall, visible next cycle
    i_Start = 1'b1;
    i_Funct = F_MTHI;
    i_RS    = 32'h1234_5678;
    #2;
    chk("mthi_no_stall", 32'(o_Stall), 32'd0);
    @(posedge i_clk);
    #1;
    i_Funct = F_MFHI;
    #1;
    chk("mthi_readback", o_Result, 32'h1234_5678);
    chk("mfhi_after_mthi_no_stall", 32'(o_Stall), 32'd0);
    chk("mthi_not_busy", 32'(o_Busy), 32'd0);
    $display("[TB] MTHI rs=12345678 -> hi=%h", o_Result);

    // Unlisted funct: ignored, no stall, HI unchanged
    @(posedge i_clk);
    #1;
    i_Funct = F_BAD;
    i_RS    = 32'hAAAA_AAAA;
    i_RT    = 32'hBBBB_BBBB;
    #2;
    chk("bad_funct_stall", 32'(o_Stall), 32'd0);
    @(posedge i_clk);
    #1;
    chk("bad_funct_busy", 32'(o_Busy), 32'd0);
    chk("bad_funct_done", 32'(o_Done), 32'd0);
    i_Funct = F_MFHI;
    #1;
    chk("bad_funct_hi_kept", o_Result, 32'h1234_5678);
    $display("[TB] BAD funct=100000 -> stall=%0d hi=%h", o_Stall, o_Result);
    @(posedge i_clk);
    #1;

    // MFLO presented while a DIV is busy: stalled until IDLE
    i_Funct = F_DIV;
    i_RS    = 32'd100;
    i_RT    = 32'd7;
    #2;
    chk("div_accept_stall", 32'(o_Stall), 32'd1);
    @(posedge i_clk);
    #1;
    i_Funct = F_MFLO;
    #4;
    n = 0;
    while (o_Stall && n < 100) begin
      n++;
      @(posedge i_clk);
      #5;
    end
    chk("mflo_while_busy_stall_cycles", 32'(n), 32'd34);
    chk("mflo_after_div", o_Result, 32'd14);
    $display("[TB] MFLO during DIV 100/7 -> stalled %0d cycles, lo=%h", n, o_Result);
    @(posedge i_clk);
    #1;
    i_Start = 1'b0;

    // Randomized operations against the reference model
    for (int k = 0; k < 24; k++) begin
      rf  = F_MULT + 6'($urandom_range(0, 3));
      rrs = $urandom;
      rrt = $urandom;
      case ($urandom_range(0, 7))
        0: rrt = 32'd0;
        1: rrt = 32'($urandom_range(1, 15));
        2: begin rrs = 32'h8000_0000; rrt = 32'hFFFF_FFFF; end
        3: rrs = 32'($urandom_range(0, 255));
        default: ;
      endcase
      model(rf, rrs, rrt, ehi, elo);
      run_md(rf, rrs, rrt, ehi, elo);
    end

    // Reset in the middle of a MULT
    i_Start = 1'b1;
    i_Funct = F_MTLO;
    i_RS    = 32'hCAFE_BABE;
    @(posedge i_clk);
    #1;
    i_Funct = F_MULT;
    i_RS    = 32'h0000_1234;
    i_RT    = 32'h0000_5678;
    @(posedge i_clk);
    repeat (10) @(posedge i_clk);
    #2;
    chk("midop_busy_before_reset", 32'(o_Busy), 32'd1);
    i_Start = 1'b0;
    i_reset = 1'b1;
    #1;
    chk("midop_reset_busy", 32'(o_Busy), 32'd0);
    chk("midop_reset_done", 32'(o_Done), 32'd0);
    chk("midop_reset_stall", 32'(o_Stall), 32'd0);
    i_Funct = F_MFHI;
    #1;
    chk("midop_reset_hi", o_Result, 32'd0);
    i_Funct = F_MFLO;
    #1;
    chk("midop_reset_lo", o_Result, 32'd0);
    n = 0;
    repeat (3) begin
      @(posedge i_clk);
      #5;
      if (o_Done) n++;
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (3) begin
      #4;
      if (o_Done || o_Busy) n++;
      @(posedge i_clk);
      #1;
    end
    chk("midop_no_done_or_busy", 32'(n), 32'd0);
    $display("[TB] RESET during MULT iteration 10 -> outputs cleared, hi/lo=0");
    run_md(F_MULT, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
